// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM states (IDLE / REQ / WAIT / HOLD)
//   ALIGN_MASK    : low PC bits that must be zero for a legal word fetch
//   is_aligned()  : applies ALIGN_MASK to the two low PC bits
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [1:0] pc_lsb);
    return (pc_lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//
// Bundles every handshake/bus signal of the fetch stage:
//   PC, fetch_en, flush          : from the PC unit / branch logic
//   imem_req, imem_addr          : request channel to instruction memory
//   imem_gnt, imem_rvalid,
//   imem_rdata                   : grant and response from instruction memory
//   Instr, instr_valid,
//   instr_ready                  : valid/ready channel to decode
//   stall, misalign_err          : status back to the PC unit
// Modports:
//   master : the fetch stage itself
//   slave  : the surrounding datapath (PC unit, memory, decode)
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] PC;
  logic              fetch_en;
  logic              flush;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  logic [DATA_W-1:0] Instr;
  logic              instr_valid;
  logic              instr_ready;

  logic              stall;
  logic              misalign_err;

  modport master (
    input  PC, fetch_en, flush,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  instr_ready,
    output imem_req, imem_addr,
    output Instr, instr_valid,
    output stall, misalign_err
  );

  modport slave (
    output PC, fetch_en, flush,
    output imem_gnt, imem_rvalid, imem_rdata,
    output instr_ready,
    input  imem_req, imem_addr,
    input  Instr, instr_valid,
    input  stall, misalign_err
  );

endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage between the PC unit and decode. On fetch_en with a
// word-aligned PC it latches the address, issues one request to instruction
// memory (req/gnt, then rvalid), and holds the returned word on Instr with
// instr_valid until decode takes it. Only one request is ever outstanding.
// A flush (taken jump/branch) drops the request, the in-flight response or
// the held word, whichever is current.
//
// Ports:
//   CLK    : clock, all state changes on the rising edge
//   reset  : synchronous, active-low reset
//   bus    : instr_fetch_if.master (PC/fetch_en/flush, imem req/gnt/rvalid,
//            Instr valid/ready, stall, misalign_err)
// -----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          CLK,
  input  logic          reset,
  instr_fetch_if.master bus
);

  fetch_state_e      state;
  fetch_state_e      state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] instr_q;
  logic              discard_q;
  logic              err_q;

  logic              pc_aligned;
  logic              hold_accept;
  logic              latch_pc;
  logic              set_err;
  logic              capture;
  logic              set_discard;
  logic              clr_discard;
  logic              imem_req;
  logic              instr_valid;
  logic              stall;

  assign pc_aligned = is_aligned(bus.PC[1:0]);

  // Decode takes the held word this cycle; flush outranks the handshake.
  assign hold_accept = (state == HOLD) && bus.instr_ready && !bus.flush;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.fetch_en && pc_aligned) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.imem_gnt) begin
          state_nxt = WAIT;
        end else if (bus.flush) begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        // A response that arrives with, or after, a flush is thrown away.
        if (bus.imem_rvalid) begin
          if (discard_q || bus.flush) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (bus.instr_ready) begin
          if (bus.fetch_en && pc_aligned) begin
            state_nxt = REQ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath-strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    latch_pc    = 1'b0;
    set_err     = 1'b0;
    capture     = 1'b0;
    set_discard = 1'b0;
    clr_discard = 1'b0;
    case (state)
      IDLE: begin
        latch_pc = bus.fetch_en && pc_aligned;
        set_err  = bus.fetch_en && !pc_aligned;
      end
      REQ: begin
        imem_req = 1'b1;
        // Granted but redirected: the response will still come and must die.
        set_discard = bus.imem_gnt && bus.flush;
      end
      WAIT: begin
        capture     = bus.imem_rvalid && !discard_q && !bus.flush;
        clr_discard = bus.imem_rvalid;
        set_discard = bus.flush && !bus.imem_rvalid;
      end
      HOLD: begin
        instr_valid = 1'b1;
        latch_pc    = hold_accept && bus.fetch_en && pc_aligned;
        set_err     = hold_accept && bus.fetch_en && !pc_aligned;
      end
      default: ;
    endcase
  end

  // The PC may only move when its value is being consumed this cycle:
  // latched from IDLE, or the held word is handed to decode.
  assign stall = bus.fetch_en
               && !((state == HOLD) && bus.instr_ready)
               && !((state == IDLE) && pc_aligned);

  // ---------------------------------------------------------------------------
  // Address / instruction / flag registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!reset) begin
      addr_q    <= '0;
      instr_q   <= '0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (latch_pc) begin
        addr_q <= bus.PC;
      end
      if (capture) begin
        instr_q <= bus.imem_rdata;
      end
      if (clr_discard) begin
        discard_q <= 1'b0;
      end else if (set_discard) begin
        discard_q <= 1'b1;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.imem_req     = imem_req;
  assign bus.imem_addr    = addr_q;
  assign bus.Instr        = instr_q;
  assign bus.instr_valid  = instr_valid;
  assign bus.stall        = stall;
  assign bus.misalign_err = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic CLK = 1'b0;
  logic reset;

  instr_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int gnt_dly = 0;
  int rv_dly  = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h1234_5678;
      32'h0040_0004: return 32'h0BAD_C0DE;
      32'h0040_0008: return 32'h89AB_CDEF;
      32'h0040_000C: return 32'hDEAD_BEEF;
      32'h0040_0010: return 32'hCAFE_F00D;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Memory model: grant after gnt_dly waiting cycles, rvalid rv_dly cycles after grant.
  int          m_gcnt = 0;
  int          m_rcnt = 0;
  bit          m_pend = 0;
  logic [31:0] m_addr = 0;
  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge CLK);
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      if (m_pend) begin
        if (m_rcnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(m_addr);
          m_pend          = 0;
        end else begin
          m_rcnt--;
        end
      end else if (bus.imem_req === 1'b1) begin
        if (m_gcnt == gnt_dly) begin
          bus.imem_gnt = 1'b1;
          m_gcnt       = 0;
          m_pend       = 1;
          m_rcnt       = rv_dly - 1;
          m_addr       = bus.imem_addr;
        end else begin
          m_gcnt++;
        end
      end else begin
        m_gcnt = 0;
      end
    end
  end

  // Monitor: each newly presented instruction is checked against the scoreboard.
  bit prev_valid = 0;
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (bus.instr_valid === 1'b1 && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_instr_valid", bus.instr_valid, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("instr_data", bus.Instr, e.data);
          chk("instr_arrival_cycle", cyc, e.cyc);
        end
      end
      prev_valid = (bus.instr_valid === 1'b1);
    end
  end

  task automatic issue(input logic [31:0] pc, input bit expect_word,
                       input logic [31:0] word, input int g, input int r);
    @(negedge CLK);
    gnt_dly      = g;
    rv_dly       = r;
    bus.PC       = pc;
    bus.fetch_en = 1'b1;
    if (expect_word) exp_q.push_back('{data: word, cyc: cyc + 2 + g + r});
  endtask

  task automatic wait_valid(input string name, input int bound);
    int k = 0;
    while (bus.instr_valid !== 1'b1 && k < bound) begin
      @(negedge CLK);
      #2;
      k++;
    end
    if (bus.instr_valid !== 1'b1) chk(name, bus.instr_valid, 1'b1);
  endtask

  task automatic accept();
    @(negedge CLK);
    bus.instr_ready = 1'b1;
    bus.fetch_en    = 1'b0;
    @(negedge CLK);
    bus.instr_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imem_req"},     bus.imem_req,     1'b0);
    chk({tag, "_imem_addr"},    bus.imem_addr,    32'h0);
    chk({tag, "_Instr"},        bus.Instr,        32'h0);
    chk({tag, "_instr_valid"},  bus.instr_valid,  1'b0);
    chk({tag, "_misalign_err"}, bus.misalign_err, 1'b0);
    chk({tag, "_stall"},        bus.stall,        1'b0);
  endtask

  initial begin
    reset           = 1'b0;
    bus.PC          = 32'h0;
    bus.fetch_en    = 1'b0;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    #2;
    chk_reset_outputs("reset");
    @(negedge CLK);
    reset = 1'b1;

    // Zero-wait fetch of 0x00400000
    issue(32'h0040_0000, 1, 32'h1234_5678, 0, 1);
    #2;
    chk("t1_stall_on_latch", bus.stall, 1'b0);
    @(negedge CLK); #2;
    chk("t1_req", bus.imem_req, 1'b1);
    chk("t1_addr", bus.imem_addr, 32'h0040_0000);
    chk("t1_stall_req", bus.stall, 1'b1);
    @(negedge CLK); #2;
    chk("t1_req_drop_after_gnt", bus.imem_req, 1'b0);
    chk("t1_stall_wait", bus.stall, 1'b1);
    wait_valid("t1_valid_timeout", 6);
    chk("t1_stall_hold", bus.stall, 1'b1);
    accept();

    // Grant delayed 3 cycles, response 2 cycles after grant
    issue(32'h0040_0008, 1, 32'h89AB_CDEF, 3, 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #2;
      chk("t2_req_held", bus.imem_req, 1'b1);
      chk("t2_addr_stable", bus.imem_addr, 32'h0040_0008);
    end
    @(negedge CLK); #2;
    chk("t2_req_drop", bus.imem_req, 1'b0);
    wait_valid("t2_valid_timeout", 8);
    accept();

    // Flush in WAIT: response 0xDEADBEEF must be dropped
    issue(32'h0040_000C, 0, 32'h0, 0, 3);
    @(negedge CLK);
    bus.fetch_en = 1'b0;
    @(negedge CLK);
    bus.flush = 1'b1;
    @(negedge CLK);
    bus.flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #2;
      chk("t3_no_valid_after_flush", bus.instr_valid, 1'b0);
    end
    chk("t3_idle_no_req", bus.imem_req, 1'b0);
    issue(32'h0040_0010, 1, 32'hCAFE_F00D, 0, 1);
    wait_valid("t3_refetch_timeout", 6);
    chk("t3_refetch_word", bus.Instr, 32'hCAFE_F00D);
    accept();

    // Flush in the same cycle as rvalid
    issue(32'h0040_000C, 0, 32'h0, 0, 1);
    @(negedge CLK);
    bus.fetch_en = 1'b0;
    @(negedge CLK);
    bus.flush = 1'b1;
    @(negedge CLK);
    bus.flush = 1'b0;
    #2;
    chk("t3b_valid_dropped", bus.instr_valid, 1'b0);
    chk("t3b_req_idle", bus.imem_req, 1'b0);

    // Flush in REQ before grant
    issue(32'h0040_0004, 0, 32'h0, 2, 1);
    @(negedge CLK); #2;
    chk("t3c_req", bus.imem_req, 1'b1);
    bus.flush    = 1'b1;
    bus.fetch_en = 1'b0;
    @(negedge CLK);
    bus.flush = 1'b0;
    #2;
    chk("t3c_req_dropped", bus.imem_req, 1'b0);
    repeat (3) @(negedge CLK);
    #2;
    chk("t3c_no_valid", bus.instr_valid, 1'b0);

    // Decode back-pressure in HOLD, then back-to-back fetch
    issue(32'h0040_0000, 1, 32'h1234_5678, 0, 1);
    wait_valid("t4_valid_timeout", 6);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); #2;
      chk("t4_instr_stable", bus.Instr, 32'h1234_5678);
      chk("t4_valid_stable", bus.instr_valid, 1'b1);
      chk("t4_stall_hold", bus.stall, 1'b1);
    end
    @(negedge CLK);
    bus.instr_ready = 1'b1;
    bus.PC          = 32'h0040_0004;
    bus.fetch_en    = 1'b1;
    gnt_dly         = 0;
    rv_dly          = 1;
    exp_q.push_back('{data: 32'h0BAD_C0DE, cyc: cyc + 3});
    #2;
    chk("t4_stall_on_accept", bus.stall, 1'b0);
    @(negedge CLK);
    bus.instr_ready = 1'b0;
    #2;
    chk("t4_b2b_req", bus.imem_req, 1'b1);
    chk("t4_b2b_addr", bus.imem_addr, 32'h0040_0004);
    chk("t4_b2b_valid_cleared", bus.instr_valid, 1'b0);
    @(negedge CLK);
    bus.fetch_en = 1'b0;
    wait_valid("t4_b2b_timeout", 6);
    accept();

    // Misaligned PC
    @(negedge CLK);
    bus.PC       = 32'h0040_0002;
    bus.fetch_en = 1'b1;
    #2;
    chk("t5_stall_misaligned", bus.stall, 1'b1);
    @(negedge CLK); #2;
    chk("t5_no_req", bus.imem_req, 1'b0);
    chk("t5_misalign_set", bus.misalign_err, 1'b1);
    @(negedge CLK);
    bus.fetch_en = 1'b0;
    repeat (2) @(negedge CLK);
    #2;
    chk("t5_misalign_sticky", bus.misalign_err, 1'b1);
    chk("t5_still_no_req", bus.imem_req, 1'b0);

    // Reset during WAIT, response arrives after reset
    issue(32'h0040_0010, 0, 32'h0, 0, 3);
    @(negedge CLK);
    bus.fetch_en = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    #2;
    chk_reset_outputs("t6");
    repeat (3) @(negedge CLK);
    #2;
    chk("t6_late_rvalid_ignored", bus.instr_valid, 1'b0);
    chk("t6_instr_still_zero", bus.Instr, 32'h0);

    // Every expected word must have been seen
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge CLK);
    chk("scoreboard_drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
